// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n64_pkg
// Description : Shared Joybus constants, command codes, transmitter state
//               encoding and slot-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package n64_pkg;

    // Console command codes
    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;

    // Bit-cell geometry in 1 us slots
    localparam int unsigned SLOTS_PER_BIT   = 4;
    localparam int unsigned ZERO_LOW_SLOTS  = 3;
    localparam int unsigned ONE_LOW_SLOTS   = 1;
    localparam int unsigned STOP_LOW_SLOTS  = 1;
    localparam int unsigned STOP_HIGH_SLOTS = 2;

    // Transmitter FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BIT_LOW   = 3'd1,
        ST_BIT_HIGH  = 3'd2,
        ST_STOP_LOW  = 3'd3,
        ST_STOP_HIGH = 3'd4
    } tx_state_t;

    // Index of the last low slot within a bit cell for a given data bit
    function automatic logic [1:0] last_low_slot(input logic b);
        return b ? 2'(ONE_LOW_SLOTS - 1) : 2'(ZERO_LOW_SLOTS - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/n64_slot_tick.sv
`default_nettype none
// ============================================================================
// Module      : n64_slot_tick
// Description : 0..CLKS_PER_US-1 cycle counter that runs while enabled and is
//               cleared on frame start. o_tick marks the last cycle of a slot,
//               o_mid marks the middle cycle of a slot.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_slot_tick #(
    parameter int CLKS_PER_US = 33
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick,
    output logic o_mid
);

    localparam int c_cnt_w = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_US - 1);
    localparam logic [c_cnt_w-1:0] c_mid  = c_cnt_w'(CLKS_PER_US / 2);

    logic [c_cnt_w-1:0] r_cnt;

    // Cycle counter within the current slot; wraps at the slot boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == c_last);
    assign o_mid  = i_en && (r_cnt == c_mid);

endmodule
`default_nettype wire

// File: rtl/n64_joybus_tx.sv
`default_nettype none
// ============================================================================
// Module      : n64_joybus_tx
// Description : Joybus transmitter. Serialises 1..MAX_BYTES command bytes
//               MSB-first as open-drain bit cells (dout_oe=1 pulls the line
//               low), followed by a console stop bit and a 2-slot release
//               guard.
//               Optional feature macro: N64_TX_LINECHK_EN - synchronises
//               din_sense and aborts (done+err) when the line is found held
//               low at start or during a released slot.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_joybus_tx
    import n64_pkg::*;
#(
    parameter int CLKS_PER_US = 33,
    parameter int MAX_BYTES   = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [8*MAX_BYTES-1:0]         tx_data,
    input  logic [$clog2(MAX_BYTES+1)-1:0] tx_len,
    input  logic                           din_sense,
    output logic                           dout_oe,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int c_len_w = $clog2(MAX_BYTES + 1);
    localparam int c_dat_w = 8 * MAX_BYTES;
    localparam logic [c_len_w-1:0] c_max_len = c_len_w'(MAX_BYTES);

    tx_state_t            r_state;
    logic [c_dat_w-1:0]   r_shift;
    logic [2:0]           r_bit_cnt;
    logic [c_len_w-1:0]   r_byte_idx;
    logic [c_len_w-1:0]   r_last_byte;
    logic [1:0]           r_slot;
    logic                 r_oe;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_tick;
    logic                 w_mid;
    logic                 w_accept;
    logic                 w_line_low;
    logic                 w_abort;
    logic                 w_cur_bit;
    logic                 w_last_bit;
    logic [c_len_w-1:0]   w_len_sat;

    assign w_len_sat  = (tx_len > c_max_len) ? c_max_len : tx_len;
    assign w_accept   = start && (r_state == ST_IDLE) && (tx_len != '0);
    assign w_cur_bit  = r_shift[c_dat_w-1];
    assign w_last_bit = (r_bit_cnt == 3'd0) && (r_byte_idx == r_last_byte);
    assign w_abort    = w_line_low && w_mid &&
                        ((r_state == ST_BIT_HIGH) || (r_state == ST_STOP_HIGH));

    n64_slot_tick #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_slot_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_accept),
        .i_en    (r_busy),
        .o_tick  (w_tick),
        .o_mid   (w_mid)
    );

`ifdef N64_TX_LINECHK_EN
    logic [1:0] r_sense_sync;

    // Two-flop synchroniser for the raw line level (idle line reads high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sense_sync <= 2'b11;
        end else begin
            r_sense_sync <= {r_sense_sync[0], din_sense};
        end
    end

    assign w_line_low = ~r_sense_sync[1];
    assign err        = r_err;
`else
    logic w_unused;

    assign w_line_low = 1'b0;
    assign err        = 1'b0;
    assign w_unused   = din_sense ^ r_err;
`endif

    // Frame sequencer: bit-cell timing, byte/bit indexing and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= 3'd0;
            r_byte_idx  <= '0;
            r_last_byte <= '0;
            r_slot      <= 2'd0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_line_low) begin
                            // Line already held low by another driver
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_shift     <= tx_data;
                            r_last_byte <= w_len_sat - 1'b1;
                            r_byte_idx  <= '0;
                            r_bit_cnt   <= 3'd7;
                            r_slot      <= 2'd0;
                            r_state     <= ST_BIT_LOW;
                            r_oe        <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end

                ST_BIT_LOW: begin
                    if (w_tick) begin
                        r_slot <= r_slot + 2'd1;
                        if (r_slot == last_low_slot(w_cur_bit)) begin
                            r_state <= ST_BIT_HIGH;
                            r_oe    <= 1'b0;
                        end
                    end
                end

                ST_BIT_HIGH: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_tick) begin
                        if (r_slot == 2'(SLOTS_PER_BIT - 1)) begin
                            r_slot <= 2'd0;
                            r_oe   <= 1'b1;
                            if (w_last_bit) begin
                                r_state <= ST_STOP_LOW;
                            end else begin
                                r_state   <= ST_BIT_LOW;
                                r_shift   <= r_shift << 1;
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                                if (r_bit_cnt == 3'd0) begin
                                    r_byte_idx <= r_byte_idx + 1'b1;
                                end
                            end
                        end else begin
                            r_slot <= r_slot + 2'd1;
                        end
                    end
                end

                ST_STOP_LOW: begin
                    if (w_tick) begin
                        if (r_slot == 2'(STOP_LOW_SLOTS - 1)) begin
                            r_state <= ST_STOP_HIGH;
                            r_oe    <= 1'b0;
                            r_slot  <= 2'd0;
                        end else begin
                            r_slot <= r_slot + 2'd1;
                        end
                    end
                end

                ST_STOP_HIGH: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_tick) begin
                        if (r_slot == 2'(STOP_HIGH_SLOTS - 1)) begin
                            r_state <= ST_IDLE;
                            r_slot  <= 2'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_slot <= r_slot + 2'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout_oe = r_oe;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire
